// File: rtl/riscv_pipe_skid_reg_pkg.sv
// Shared width default and state encoding for the pipeline skid register.
package riscv_pipe_skid_reg_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    PSR_EMPTY = 2'd0,
    PSR_ONE   = 2'd1,
    PSR_FULL  = 2'd2
  } psr_state_e;

endpackage

// File: rtl/riscv_pipe_skid_reg_slot.sv
// One payload slot: load-enabled register with asynchronous reset to a fixed init value.
module riscv_pipe_skid_reg_slot
  import riscv_pipe_skid_reg_pkg::*;
#(
  parameter int            DW   = XLEN,
  parameter logic [DW-1:0] INIT = '0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [DW-1:0] i_d,
  output logic [DW-1:0] o_q
);

  logic [DW-1:0] slot_q;

  // Slot storage; holds its value unless a load is requested.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      slot_q <= INIT;
    end else if (i_load) begin
      slot_q <= i_d;
    end else begin
      slot_q <= slot_q;
    end
  end

  assign o_q = slot_q;

endmodule

// File: rtl/riscv_pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake, 2-entry skid buffer and flush.
module riscv_pipe_skid_reg
  import riscv_pipe_skid_reg_pkg::*;
#(
  parameter int            DW       = XLEN,
  parameter logic [DW-1:0] REG_INIT = '0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_flush,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data,
  output logic [1:0]    o_count
);

  psr_state_e    state_q;
  psr_state_e    state_d;
  logic          in_fire_s;
  logic          out_fire_s;
  logic          main_load_s;
  logic          skid_load_s;
  logic [DW-1:0] main_d;
  logic [DW-1:0] main_q;
  logic [DW-1:0] skid_q;

  // Handshake outputs come straight from the state flop, so no path i_ready -> o_ready.
  assign o_valid    = (state_q != PSR_EMPTY);
  assign o_ready    = (state_q != PSR_FULL);
  assign o_count    = state_q;
  assign o_data     = main_q;
  assign in_fire_s  = i_valid & o_ready;
  assign out_fire_s = o_valid & i_ready;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= PSR_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and slot steering; a flush empties the stage but leaves slot contents alone.
  always_comb begin
    state_d     = state_q;
    main_load_s = 1'b0;
    skid_load_s = 1'b0;
    main_d      = i_data;
    case (state_q)
      PSR_EMPTY: begin
        if (in_fire_s) begin
          main_load_s = 1'b1;
          state_d     = PSR_ONE;
        end else begin
          state_d     = PSR_EMPTY;
        end
      end
      PSR_ONE: begin
        if (in_fire_s && out_fire_s) begin
          main_load_s = 1'b1;
          state_d     = PSR_ONE;
        end else if (in_fire_s) begin
          skid_load_s = 1'b1;
          state_d     = PSR_FULL;
        end else if (out_fire_s) begin
          state_d     = PSR_EMPTY;
        end else begin
          state_d     = PSR_ONE;
        end
      end
      PSR_FULL: begin
        if (out_fire_s) begin
          main_load_s = 1'b1;
          main_d      = skid_q;
          state_d     = PSR_ONE;
        end else begin
          state_d     = PSR_FULL;
        end
      end
      default: begin
        state_d = PSR_EMPTY;
      end
    endcase
    if (i_flush) begin
      state_d     = PSR_EMPTY;
      main_load_s = 1'b0;
      skid_load_s = 1'b0;
    end else begin
      state_d     = state_d;
    end
  end

  riscv_pipe_skid_reg_slot #(.DW(DW), .INIT(REG_INIT)) u_main (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (main_load_s),
    .i_d    (main_d),
    .o_q    (main_q)
  );

  riscv_pipe_skid_reg_slot #(.DW(DW), .INIT(REG_INIT)) u_skid (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (skid_load_s),
    .i_d    (i_data),
    .o_q    (skid_q)
  );

endmodule
